bcd_scan_mux: RTL and testbench
===============================

// Module: bcd_scan_mux
// PURPOSE
//  Parametrised time-multiplexed BCD display scanner for the 7-segment path.
//  - Owns its refresh counter; no external counter needed.
//  - Cycles NUM_DIGITS BCD digits onto one digit bus and drives active-low anode selects.
//  - New digit sets load through a valid/ready handshake, applied only at frame boundaries, so no tearing.
//  - Optional leading-zero blanking; per-build bit-reverse/invert mapping to the downstream decoder.
// PARAMETERS
//  NUM_DIGITS    4       digits scanned, 2..8; slot 0 = rightmost (ones)
//  REFRESH_DIV   100000  clk cycles per digit slot, >=2 (1 kHz/slot at 100 MHz)
//  REVERSE_BITS  1       1: one_digit bit order reversed {d[0],d[1],d[2],d[3]}
//  INVERT_OUT    1       1: one_digit bitwise inverted (after reversal)
//  BLANK_LEADING 1       1: blank zero digits above highest non-zero digit
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             synchronous reset, active-low
//  digits_in    in   4*NUM_DIGITS  BCD digits; [3:0] = slot 0
//  load_valid   in   1             digits_in valid for capture
//  load_ready   out  1             capture possible this cycle
//  one_digit    out  4             mapped BCD code of active slot
//  an_n         out  NUM_DIGITS    anode enables, one-hot-low, all-1 = off
//  slot_idx     out  clog2(N)      index of active slot
//  frame_tick   out  1             1-cycle pulse when slot N-1 ends (frame wrap)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk; priority over every other input):
//  - prescaler=0, slot_idx=0, an_n=all 1, one_digit=4'h0.
//  - display and pending registers = 0; load_ready=1; frame_tick=0.
//  Prescaler:
//  - Counts 0..REFRESH_DIV-1. slot_tick asserts when count = REFRESH_DIV-1, then wraps to 0.
//  - On slot_tick, slot_idx advances; N-1 wraps to 0.
//  - frame_tick = registered (slot_tick && slot_idx==N-1), so it is high the cycle slot_idx becomes 0.
//  Outputs:
//  - one_digit, an_n and slot_idx are registered.
//  - They reflect the new slot in the cycle after slot_tick (latency 1).
//  - an_n[k]=0 only for k==slot_idx and slot not blanked.
//  Mapping:
//  - raw = display[slot_idx].
//  - If REVERSE_BITS, reverse the bit order.
//  - If INVERT_OUT, apply ~.
//  - Non-BCD values (A-F) pass through unchanged.
//  Blanking:
//  - Slot k is blanked iff BLANK_LEADING, k>0, and all display digits k..N-1 are zero.
//  - Slot 0 is never blanked, so 0000 shows "0".
//  - Blanked slot: an_n=all 1; one_digit still carries the mapped code.
//  Handshake:
//  - Capture: load_valid && load_ready at posedge copies digits_in to pending; load_ready=0 next cycle.
//  - Apply: at the slot_tick ending slot N-1, if pending is full, pending -> display; load_ready=1 next cycle.
//  - The first slot of the new frame shows the new data.
//  - Capture in the same cycle as that wrap tick does not apply this frame; it waits for the next wrap.
//  - load_valid while load_ready=0 is ignored. Producer must hold until ready.
//  - Reset mid-frame or with a pending load discards pending; display returns to 0.
//  Widths:
//  - slot_idx width = max(1, clog2(NUM_DIGITS)).
//  - Prescaler width = clog2(REFRESH_DIV).
//  - No arithmetic overflow beyond these wraps.
// STRUCTURE
//  Package bcd_scan_pkg:
//  - BCD_W=4 and the clog2 helper.
//  - bit-reverse function and blank-code constant.
//  - DEFAULT_REFRESH_DIV=100000.
//  Sub-module refresh_prescaler (params DIV; ports clk, rst_n, tick):
//  - Reused by the other display blocks.
//  Top holds the slot counter, pending/display registers, handshake, blanking and output registers.
// TESTING (REFRESH_DIV=4, N=4 unless noted)
//  1. Reset, then load 4'h1,2,3,4 (slot0..3), REV=0, INV=0
//     -> after the first wrap, one_digit sequence 1,2,3,4 repeating, each held 4 clk.
//     -> an_n sequence 1110,1101,1011,0111; frame_tick every 16 clk.
//  2. REV=1, INV=1, digit 4'b0001 -> one_digit=4'b0111; digit 4'h0 -> 4'hF.
//  3. Blanking on, digits 0,0,0,7 (slot3..0)
//     -> slots 3..1 an_n=1111; slot0 an_n=1110; one_digit=7.
//     -> all-zero input: only slot 0 lit, showing 0.
//  4. load_valid in slot 1 -> load_ready low until the tick ending slot 3.
//     -> new data first seen on slot 0 of the next frame.
//     -> second load_valid while not ready is ignored.
//  5. load_valid on the exact wrap tick -> applied one frame later, not immediately.
//  6. rst_n=0 mid-slot with a load pending -> next cycle all outputs at reset values.
//     -> pending dropped; scan restarts at slot 0.

Source files
------------

// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg: shared widths and helpers for the 7-segment scan path.
package bcd_scan_pkg;
    localparam int BCD_W = 4;
    localparam int DEFAULT_REFRESH_DIV = 100000;
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    function automatic logic [BCD_W-1:0] rev_bits(input logic [BCD_W-1:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: free-running divider pulsing tick once every DIV clocks.
module refresh_prescaler import bcd_scan_pkg::*; #(
    parameter int DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else cnt <= tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: time-multiplexed BCD digit scanner with frame-aligned load handshake.
module bcd_scan_mux import bcd_scan_pkg::*; #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = DEFAULT_REFRESH_DIV,
    parameter bit REVERSE_BITS  = 1,
    parameter bit INVERT_OUT    = 1,
    parameter bit BLANK_LEADING = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic                          load_valid,
    output logic                          load_ready,
    output logic [BCD_W-1:0]              one_digit,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [clog2(NUM_DIGITS)-1:0]  slot_idx,
    output logic                          frame_tick
);
    localparam int SW = clog2(NUM_DIGITS);
    localparam logic [SW-1:0] LAST = SW'(NUM_DIGITS - 1);
    logic slot_tick, wrap, full, blank;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] pending, display, nxt_display;
    logic [SW-1:0] nxt_slot;
    logic [BCD_W-1:0] raw, ordered, mapped;
    logic [NUM_DIGITS-1:0] zero_above;
    refresh_prescaler #(.DIV(REFRESH_DIV)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (slot_tick)
    );
    assign wrap = slot_tick && slot_idx == LAST;
    assign load_ready = !full;
    assign nxt_slot = slot_tick ? (wrap ? '0 : slot_idx + SW'(1)) : slot_idx;
    // Outputs are registered from next-state values so they line up with slot_idx.
    assign nxt_display = (wrap && full) ? pending : display;
    assign raw = nxt_display[nxt_slot];
    assign ordered = REVERSE_BITS ? rev_bits(raw) : raw;
    assign mapped = INVERT_OUT ? ~ordered : ordered;
    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = nxt_display[NUM_DIGITS-1] == '0;
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            zero_above[k] = zero_above[k+1] && nxt_display[k] == '0;
    end
    assign blank = BLANK_LEADING && nxt_slot != '0 && zero_above[nxt_slot];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_idx   <= '0;
            an_n       <= '1;
            one_digit  <= '0;
            frame_tick <= 1'b0;
            display    <= '0;
            pending    <= '0;
            full       <= 1'b0;
        end else begin
            slot_idx   <= nxt_slot;
            display    <= nxt_display;
            frame_tick <= wrap;
            one_digit  <= mapped;
            an_n       <= blank ? '1 : ~(NUM_DIGITS'(1) << nxt_slot);
            if (load_valid && load_ready) begin
                pending <= digits_in;
                full    <= 1'b1;
            end else if (wrap) begin
                full    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb_bcd_scan_mux: directed checks of scan order, mapping, blanking, handshake and reset.
module tb_bcd_scan_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_valid = 1'b0;
    logic [15:0] digits_in = '0;
    logic ready_a, ready_b, ft_a, ft_b;
    logic [3:0] one_a, one_b, an_a, an_b;
    logic [1:0] slot_a, slot_b;
    logic [3:0] map_b [4] = '{4'h7, 4'hB, 4'h3, 4'hD};
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    bcd_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .REVERSE_BITS(0), .INVERT_OUT(0), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load_valid(load_valid), .load_ready(ready_a),
        .one_digit(one_a), .an_n(an_a), .slot_idx(slot_a), .frame_tick(ft_a)
    );
    bcd_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .REVERSE_BITS(1), .INVERT_OUT(1), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load_valid(load_valid), .load_ready(ready_b),
        .one_digit(one_b), .an_n(an_b), .slot_idx(slot_b), .frame_tick(ft_b)
    );
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wait_frame();
        int i = 0;
        step(1);
        while (!ft_a && i < 40) begin
            step(1);
            i++;
        end
        check("frame_wait", 16'(ft_a), 16'h1);
    endtask
    task automatic load(input logic [15:0] d);
        digits_in = d;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
    endtask
    function automatic logic [3:0] an_of(input int s);
        logic [3:0] hot;
        hot = 4'b0001 << s;
        return ~hot;
    endfunction
    initial begin
        step(2);
        check("rst_an", 16'(an_a), 16'hF);
        check("rst_one", 16'(one_a), 16'h0);
        check("rst_one_b", 16'(one_b), 16'h0);
        check("rst_slot", 16'(slot_a), 16'h0);
        check("rst_ready", 16'(ready_a), 16'h1);
        check("rst_frame", 16'(ft_a), 16'h0);
        rst_n = 1'b1;
        load(16'h4321);
        check("t1_ready_low", 16'(ready_a), 16'h0);
        wait_frame();
        check("t1_ready_back", 16'(ready_a), 16'h1);
        for (int s = 0; s < 4; s++) begin
            check("t1_slot", 16'(slot_a), 16'(s));
            check("t1_one", 16'(one_a), 16'(s + 1));
            check("t1_an", 16'(an_a), 16'(an_of(s)));
            check("t2_map", 16'(one_b), 16'(map_b[s]));
            step(3);
            check("t1_hold", 16'(slot_a), 16'(s));
            check("t1_ft_low", 16'(ft_a), 16'h0);
            step(1);
        end
        check("t1_ft_period", 16'(ft_a), 16'h1);
        check("t1_wrap_slot", 16'(slot_a), 16'h0);
        load(16'h0007);
        wait_frame();
        for (int s = 0; s < 4; s++) begin
            check("t3_an", 16'(an_a), (s == 0) ? 16'hE : 16'hF);
            check("t3_one", 16'(one_a), (s == 0) ? 16'h7 : 16'h0);
            check("t3_an_noblank", 16'(an_b), 16'(an_of(s)));
            check("t2_zero_map", 16'(one_b), (s == 0) ? 16'h1 : 16'hF);
            step(4);
        end
        load(16'h0000);
        wait_frame();
        check("t3_zero_an0", 16'(an_a), 16'hE);
        check("t3_zero_one0", 16'(one_a), 16'h0);
        step(4);
        check("t3_zero_an1", 16'(an_a), 16'hF);
        load(16'h0700);
        wait_frame();
        for (int s = 0; s < 4; s++) begin
            check("t3_mid_an", 16'(an_a), (s == 3) ? 16'hF : 16'(an_of(s)));
            step(4);
        end
        step(4);
        digits_in = 16'h5678;
        load_valid = 1'b1;
        step(1);
        check("t4_ready_low", 16'(ready_a), 16'h0);
        digits_in = 16'h9999;
        step(9);
        load_valid = 1'b0;
        step(1);
        check("t4_still_low", 16'(ready_a), 16'h0);
        check("t4_old_slot", 16'(slot_a), 16'h3);
        check("t4_old_an", 16'(an_a), 16'hF);
        step(1);
        check("t4_frame", 16'(ft_a), 16'h1);
        check("t4_ready_up", 16'(ready_a), 16'h1);
        check("t4_new0", 16'(one_a), 16'h8);
        for (int s = 1; s < 4; s++) begin
            step(4);
            check("t4_new", 16'(one_a), 16'(8 - s));
        end
        step(3);
        digits_in = 16'h1111;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
        check("t5_frame", 16'(ft_a), 16'h1);
        check("t5_ready_low", 16'(ready_a), 16'h0);
        check("t5_not_yet", 16'(one_a), 16'h8);
        wait_frame();
        check("t5_applied", 16'(one_a), 16'h1);
        check("t5_ready_up", 16'(ready_a), 16'h1);
        step(1);
        load(16'h2222);
        check("t6_pending", 16'(ready_a), 16'h0);
        rst_n = 1'b0;
        step(1);
        check("t6_an", 16'(an_a), 16'hF);
        check("t6_one", 16'(one_a), 16'h0);
        check("t6_slot", 16'(slot_a), 16'h0);
        check("t6_ready", 16'(ready_a), 16'h1);
        check("t6_frame", 16'(ft_a), 16'h0);
        rst_n = 1'b1;
        step(1);
        check("t6_restart_an", 16'(an_a), 16'hE);
        check("t6_restart_one", 16'(one_a), 16'h0);
        check("t6_restart_b", 16'(one_b), 16'hF);
        step(15);
        check("t6_first_frame", 16'(ft_a), 16'h1);
        check("t6_dropped", 16'(one_a), 16'h0);
        check("t6_slot0", 16'(slot_a), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
